ps2_mouse_receiver: RTL and testbench

- Host-side PS/2 receiver. Deserialises 11-bit device-to-host frames from the mouse: start bit, 8 data bits LSB-first, odd parity bit, stop bit.
- Sits beside the mouse transmitter under the mouse master state machine. It shares the tri-stated CLK_MOUSE/DATA_MOUSE lines, using the input side only.
- Delivers one byte per frame with a one-cycle ready strobe and an error code.

---
 rtl/ps2_mouse_receiver_pkg.sv | 35 +++
 rtl/ps2_mouse_receiver_if.sv | 30 +++
 rtl/ps2_mouse_receiver_edge_detect.sv | 57 +++++
 rtl/ps2_mouse_receiver.sv | 126 ++++++++++++
 tb/tb_ps2_mouse_receiver.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/ps2_mouse_receiver_pkg.sv
// -----------------------------------------------------------------------------
// ps2_pkg : shared types and constants for the PS/2 mouse receive path.
//   state_t        receiver frame states (IDLE, DATA, PARITY, STOP, DONE)
//   PS2_DATA_BITS  data bits per device-to-host frame
//   ERR_*          BYTE_ERROR_CODE encodings (bit0 parity, bit1 stop)
//   frame_error()  error code for a captured data byte, parity bit and stop bit
// -----------------------------------------------------------------------------
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DATA,
      PARITY,
      STOP,
      DONE
   } state_t;

   localparam int PS2_DATA_BITS = 8;

   localparam logic [1:0] ERR_NONE   = 2'b00;
   localparam logic [1:0] ERR_PARITY = 2'b01;
   localparam logic [1:0] ERR_STOP   = 2'b10;

   // Odd parity: the nine data+parity bits must hold an odd number of ones.
   function automatic logic [1:0] frame_error(input logic [PS2_DATA_BITS-1:0] data,
                                              input logic parity,
                                              input logic stop);
      logic [1:0] code;
      code = ERR_NONE;
      if (~(^data ^ parity)) code = code | ERR_PARITY;
      if (!stop)             code = code | ERR_STOP;
      return code;
   endfunction

endpackage

// File: rtl/ps2_mouse_receiver_if.sv
// -----------------------------------------------------------------------------
// ps2_mouse_receiver_if : mouse-line and byte-delivery signals of the receiver.
//   CLK_MOUSE_IN / DATA_MOUSE_IN  raw mouse lines (asynchronous to CLK)
//   READ_ENABLE                   reception permitted when high
//   BYTE_READ / BYTE_ERROR_CODE   last received byte and its error code
//   BYTE_READY                    one-cycle strobe for a new byte
// modport master : mouse master state machine side (drives lines and enable)
// modport slave  : receiver side
// -----------------------------------------------------------------------------
interface ps2_mouse_receiver_if;
   import ps2_pkg::*;

   logic                     CLK_MOUSE_IN;
   logic                     DATA_MOUSE_IN;
   logic                     READ_ENABLE;
   logic [PS2_DATA_BITS-1:0] BYTE_READ;
   logic [1:0]               BYTE_ERROR_CODE;
   logic                     BYTE_READY;

   modport master (
      output CLK_MOUSE_IN, DATA_MOUSE_IN, READ_ENABLE,
      input  BYTE_READ, BYTE_ERROR_CODE, BYTE_READY
   );

   modport slave (
      input  CLK_MOUSE_IN, DATA_MOUSE_IN, READ_ENABLE,
      output BYTE_READ, BYTE_ERROR_CODE, BYTE_READY
   );

endinterface

// File: rtl/ps2_mouse_receiver_edge_detect.sv
// -----------------------------------------------------------------------------
// ps2_edge_detect : synchroniser and falling-edge pulse for a PS/2 clock line.
//   clk, rst  system clock, asynchronous active-high reset
//   line_in   raw asynchronous line
//   fe        one-cycle pulse when the conditioned level goes 1 -> 0
// Build option PS2_RX_GLITCH_FILTER_EN inserts a 4-sample stability filter
// between the synchroniser and the edge detector.
// -----------------------------------------------------------------------------
module ps2_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic line_in,
   output logic fe
);

   logic [1:0] sync_q;
   logic       level;
   logic       level_prev_q;

   // NOTE: synchroniser flops preset to 1 so leaving reset on an idle bus
   // cannot fabricate a falling edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= 2'b11;
      else     sync_q <= {sync_q[0], line_in};
   end

`ifdef PS2_RX_GLITCH_FILTER_EN
   logic [3:0] hist_q;
   logic       filt_q;

   // Level only moves after four consecutive equal synchronised samples.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist_q <= 4'hF;
         filt_q <= 1'b1;
      end else begin
         hist_q <= {hist_q[2:0], sync_q[1]};
         if (&hist_q)       filt_q <= 1'b1;
         else if (~|hist_q) filt_q <= 1'b0;
      end
   end

   assign level = filt_q;
`else
   assign level = sync_q[1];
`endif

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbours.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) level_prev_q <= 1'b1;
      else     level_prev_q <= level;
   end

   assign fe = level_prev_q & ~level;

endmodule

// File: rtl/ps2_mouse_receiver.sv
// -----------------------------------------------------------------------------
// ps2_mouse_receiver : host-side PS/2 device-to-host frame receiver.
//   CLK    system clock (100 MHz)
//   RESET  asynchronous, active-high reset
//   bus    ps2_mouse_receiver_if.slave: mouse lines, READ_ENABLE, byte outputs
// Frame: start(0), 8 data bits LSB first, odd parity, stop(1). One BYTE_READY
// strobe per complete frame; error frames are still delivered with a code.
// Parameters: TIMEOUT_CYCLES max CLK cycles between mouse-clock falling edges
// inside a frame; TIMEOUT_W counter width (2**TIMEOUT_W > TIMEOUT_CYCLES).
// Build option PS2_RX_GLITCH_FILTER_EN enables the mouse-clock glitch filter.
// -----------------------------------------------------------------------------
module ps2_mouse_receiver
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 20000,
   parameter int TIMEOUT_W      = 15
) (
   input  logic                 CLK,
   input  logic                 RESET,
   ps2_mouse_receiver_if.slave  bus
);

   localparam int                   CNT_W         = $clog2(PS2_DATA_BITS);
   localparam logic [CNT_W-1:0]     LAST_BIT      = CNT_W'(PS2_DATA_BITS - 1);
   localparam logic [TIMEOUT_W-1:0] TIMEOUT_LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES);

   logic                     clk_fe;
   logic [1:0]               data_sync_q;
   logic                     data_bit;

   state_t                   state_q;
   logic [CNT_W-1:0]         bit_cnt_q;
   logic [PS2_DATA_BITS-1:0] shift_q;
   logic                     parity_q;
   logic                     stop_q;
   logic [TIMEOUT_W-1:0]     timeout_q;
   logic [PS2_DATA_BITS-1:0] byte_read_q;
   logic [1:0]               error_code_q;
   logic                     byte_ready_q;

   logic                     in_frame;
   logic                     timed_out;

   ps2_edge_detect u_clk_edge (
      .clk     (CLK),
      .rst     (RESET),
      .line_in (bus.CLK_MOUSE_IN),
      .fe      (clk_fe)
   );

   // Data line gets the same two-flop depth as the unfiltered clock path, so
   // the sample taken on fe belongs to the bit the clock edge framed.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) data_sync_q <= 2'b11;
      else       data_sync_q <= {data_sync_q[0], bus.DATA_MOUSE_IN};
   end

   assign data_bit  = data_sync_q[1];
   assign in_frame  = (state_q == DATA) || (state_q == PARITY) || (state_q == STOP);
   assign timed_out = in_frame && (timeout_q == TIMEOUT_LIMIT);

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q      <= IDLE;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         parity_q     <= 1'b0;
         stop_q       <= 1'b0;
         timeout_q    <= '0;
         byte_read_q  <= '0;
         error_code_q <= ERR_NONE;
         byte_ready_q <= 1'b0;
      end else begin
         byte_ready_q <= 1'b0;

         if (in_frame && !clk_fe) timeout_q <= timeout_q + TIMEOUT_W'(1);
         else                     timeout_q <= '0;

         // Abort and timeout take priority over any edge arriving this cycle.
         if (in_frame && (!bus.READ_ENABLE || timed_out)) begin
            state_q   <= IDLE;
            timeout_q <= '0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (clk_fe && bus.READ_ENABLE && !data_bit) begin
                     state_q   <= DATA;
                     bit_cnt_q <= '0;
                  end
               end
               DATA: begin
                  if (clk_fe) begin
                     shift_q[bit_cnt_q] <= data_bit;
                     bit_cnt_q          <= bit_cnt_q + CNT_W'(1);
                     if (bit_cnt_q == LAST_BIT) state_q <= PARITY;
                  end
               end
               PARITY: begin
                  if (clk_fe) begin
                     parity_q <= data_bit;
                     state_q  <= STOP;
                  end
               end
               STOP: begin
                  if (clk_fe) begin
                     stop_q  <= data_bit;
                     state_q <= DONE;
                  end
               end
               DONE: begin
                  byte_read_q  <= shift_q;
                  error_code_q <= frame_error(shift_q, parity_q, stop_q);
                  byte_ready_q <= 1'b1;
                  state_q      <= IDLE;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign bus.BYTE_READ       = byte_read_q;
   assign bus.BYTE_ERROR_CODE = error_code_q;
   assign bus.BYTE_READY      = byte_ready_q;

endmodule

// File: tb/tb_ps2_mouse_receiver.sv
// -----------------------------------------------------------------------------
// tb_ps2_mouse_receiver : self-checking bench for ps2_mouse_receiver.
// A frame-level model predicts each delivered byte and error code from the
// bits sent; one compare process checks the outputs every CLK cycle.
// The timeout is shortened to keep frames short in simulation time.
// -----------------------------------------------------------------------------
module tb_ps2_mouse_receiver;

   localparam int HALF    = 20;   // mouse clock half period in CLK cycles
   localparam int TIMEOUT = 200;

   typedef struct {
      logic [7:0] b;
      logic [1:0] e;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   ps2_mouse_receiver_if bus ();

   ps2_mouse_receiver #(
      .TIMEOUT_CYCLES (TIMEOUT),
      .TIMEOUT_W      (8)
   ) dut (
      .CLK   (clk),
      .RESET (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int         n_pass    = 0;
   int         n_total   = 0;
   int         n_strobes = 0;
   exp_t       exp_q[$];
   exp_t       cmp_item;
   logic [7:0] exp_byte  = 8'h00;
   logic [1:0] exp_err   = 2'b00;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_total++;
      if (act !== expv) $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      else              n_pass++;
   endtask

   // Per-cycle compare: outputs must always equal the last byte the model
   // expects to have been delivered; every strobe must consume one prediction.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            exp_byte = 8'h00;
            exp_err  = 2'b00;
            check("reset_ready", {31'd0, bus.BYTE_READY}, 0);
         end else if (bus.BYTE_READY) begin
            n_strobes++;
            check("strobe_expected", {31'd0, exp_q.size() != 0}, 1);
            if (exp_q.size() != 0) begin
               cmp_item = exp_q.pop_front();
               exp_byte = cmp_item.b;
               exp_err  = cmp_item.e;
            end
         end
         check("byte_read", {24'd0, bus.BYTE_READ}, {24'd0, exp_byte});
         check("byte_error_code", {30'd0, bus.BYTE_ERROR_CODE}, {30'd0, exp_err});
      end
   end

   initial begin
      #10_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Sends frame bits lo..hi; data changes while the mouse clock is high.
   task automatic send_range(input logic [10:0] fr, input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         bus.DATA_MOUSE_IN = fr[i];
         wait_cycles(HALF);
         bus.CLK_MOUSE_IN = 1'b0;
         wait_cycles(HALF);
         bus.CLK_MOUSE_IN = 1'b1;
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
      logic [10:0] fr;
      exp_t        it;
      fr = {s, p, d, 1'b0};
      send_range(fr, 0, 9);
      if (bus.READ_ENABLE) begin
         it.b    = d;
         it.e[0] = ($countones({d, p}) % 2) == 0;
         it.e[1] = !s;
         exp_q.push_back(it);
      end
      send_range(fr, 10, 10);
      bus.DATA_MOUSE_IN = 1'b1;
      wait_cycles(12);
      check("strobe_arrived", exp_q.size(), 0);
   endtask

   int          s0;
   logic [7:0]  rd;
   logic        rp;
   logic        rs;
   int          sel;

   initial begin
      bus.CLK_MOUSE_IN  = 1'b1;
      bus.DATA_MOUSE_IN = 1'b1;
      bus.READ_ENABLE   = 1'b1;
      wait_cycles(4);
      check("rst_byte", {24'd0, bus.BYTE_READ}, 32'h00);
      check("rst_code", {30'd0, bus.BYTE_ERROR_CODE}, 32'h0);
      check("rst_ready", {31'd0, bus.BYTE_READY}, 32'h0);
      @(posedge clk); #2 rst = 1'b0;
      wait_cycles(5);

      // Nominal byte 0xFA, correct parity.
      s0 = n_strobes;
      send_frame(8'hFA, 1'b1, 1'b1);
      check("nom_byte", {24'd0, bus.BYTE_READ}, 32'hFA);
      check("nom_code", {30'd0, bus.BYTE_ERROR_CODE}, 32'h0);
      check("nom_strobes", n_strobes - s0, 1);
      wait_cycles(50);
      check("nom_no_second", n_strobes - s0, 1);

      // Parity error.
      send_frame(8'h00, 1'b0, 1'b1);
      check("par_byte", {24'd0, bus.BYTE_READ}, 32'h00);
      check("par_code", {30'd0, bus.BYTE_ERROR_CODE}, 32'h1);

      // Stop-bit error.
      send_frame(8'h08, 1'b0, 1'b0);
      check("stop_byte", {24'd0, bus.BYTE_READ}, 32'h08);
      check("stop_code", {30'd0, bus.BYTE_ERROR_CODE}, 32'h2);

      // Timeout on a partial frame, then recovery.
      s0 = n_strobes;
      send_range({1'b1, 1'b0, 8'h08, 1'b0}, 0, 4);
      bus.DATA_MOUSE_IN = 1'b1;
      wait_cycles(TIMEOUT + 50);
      check("to_no_strobe", n_strobes - s0, 0);
      check("to_hold_code", {30'd0, bus.BYTE_ERROR_CODE}, 32'h2);
      send_frame(8'h08, 1'b0, 1'b1);
      check("to_rec_byte", {24'd0, bus.BYTE_READ}, 32'h08);
      check("to_rec_code", {30'd0, bus.BYTE_ERROR_CODE}, 32'h0);
      check("to_rec_strobes", n_strobes - s0, 1);

      // Gated full frame.
      s0 = n_strobes;
      bus.READ_ENABLE = 1'b0;
      send_frame(8'hFA, 1'b1, 1'b1);
      bus.READ_ENABLE = 1'b1;
      check("gate_hold_byte", {24'd0, bus.BYTE_READ}, 32'h08);
      check("gate_no_strobe", n_strobes - s0, 0);

      // Enable dropped after three data bits.
      send_range({1'b1, 1'b1, 8'hFA, 1'b0}, 0, 3);
      bus.READ_ENABLE = 1'b0;
      send_range({1'b1, 1'b1, 8'hFA, 1'b0}, 4, 10);
      bus.DATA_MOUSE_IN = 1'b1;
      wait_cycles(20);
      bus.READ_ENABLE = 1'b1;
      check("abort_no_strobe", n_strobes - s0, 0);

      // Reset mid-frame, then a clean frame.
      send_range({1'b1, 1'b1, 8'h3C, 1'b0}, 0, 5);
      @(posedge clk); #2 rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check("rstmid_byte", {24'd0, bus.BYTE_READ}, 32'h00);
      check("rstmid_code", {30'd0, bus.BYTE_ERROR_CODE}, 32'h0);
      check("rstmid_ready", {31'd0, bus.BYTE_READY}, 32'h0);
      @(posedge clk); #2 rst = 1'b0;
      bus.DATA_MOUSE_IN = 1'b1;
      wait_cycles(20);
      send_frame(8'h3C, 1'b1, 1'b1);
      check("rstmid_rec_byte", {24'd0, bus.BYTE_READ}, 32'h3C);
      check("rstmid_rec_code", {30'd0, bus.BYTE_ERROR_CODE}, 32'h0);

      // Random frames: mostly clean, some parity/stop errors, some gated.
      for (int k = 0; k < 40; k++) begin
         rd  = 8'($urandom);
         sel = int'($urandom_range(0, 9));
         rp  = (sel == 0) ? (^rd) : ~(^rd);
         rs  = (sel == 1) ? 1'b0 : 1'b1;
         bus.READ_ENABLE = (sel == 2) ? 1'b0 : 1'b1;
         send_frame(rd, rp, rs);
         bus.READ_ENABLE = 1'b1;
         wait_cycles(int'($urandom_range(5, 40)));
      end

      check("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
